// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the shared register-file write port
// Writes to ZERO (36) or any index above it are consumed and counted, never forwarded.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 64,
   parameter int IDX_W   = 8,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*IDX_W-1:0]  req_idx,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      wr_en,
   output logic [IDX_W-1:0]          wr_idx,
   output logic [DATA_W-1:0]         wr_data,
   input  logic                      wr_ready,
   output logic                      err_bad_idx,
   output logic [2:0]                err_src,
   output logic [CNT_W-1:0]          drop_count
);

   localparam logic [IDX_W-1:0] IDX_LAST_REAL = IDX_W'(35);
   localparam logic [IDX_W-1:0] IDX_ZERO      = IDX_W'(36);

   logic [2:0]        r_ptr;
   logic              r_wr_en;
   logic [IDX_W-1:0]  r_wr_idx;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_err;
   logic [2:0]        r_err_src;
   logic [CNT_W-1:0]  r_drop;

   logic                      w_free;
   logic                      w_gnt_any;
   logic [2:0]                w_gnt;
   logic [IDX_W-1:0]          w_sel_idx;
   logic [DATA_W-1:0]         w_sel_data;
   logic [NUM_REQ-1:0]        w_valid_sh;
   logic [NUM_REQ*IDX_W-1:0]  w_idx_sh;
   logic [NUM_REQ*DATA_W-1:0] w_data_sh;

   assign w_free = !r_wr_en || wr_ready;

   // Search upward from the pointer with wrap; the first valid requester wins.
   always_comb begin
      int j;
      j          = 0;
      w_gnt_any  = 1'b0;
      w_gnt      = 3'd0;
      w_valid_sh = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(r_ptr) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         w_valid_sh = req_valid >> j;
         if (!w_gnt_any && w_valid_sh[0]) begin
            w_gnt_any = 1'b1;
            w_gnt     = 3'(j);
         end
      end
   end

   always_comb begin
      w_idx_sh   = req_idx >> (int'(w_gnt) * IDX_W);
      w_data_sh  = req_data >> (int'(w_gnt) * DATA_W);
      w_sel_idx  = w_idx_sh[IDX_W-1:0];
      w_sel_data = w_data_sh[DATA_W-1:0];
   end

   always_comb begin
      req_ready = '0;
      if (w_free && w_gnt_any) begin
         req_ready = NUM_REQ'(1) << w_gnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= 3'd0;
         r_wr_en   <= 1'b0;
         r_wr_idx  <= '0;
         r_wr_data <= '0;
         r_err     <= 1'b0;
         r_err_src <= 3'd0;
         r_drop    <= '0;
      end else begin
         r_err <= 1'b0;
         if (w_free && w_gnt_any) begin
            r_ptr <= (int'(w_gnt) == NUM_REQ - 1) ? 3'd0 : w_gnt + 3'd1;
            if (w_sel_idx <= IDX_LAST_REAL) begin
               r_wr_en   <= 1'b1;
               r_wr_idx  <= w_sel_idx;
               r_wr_data <= w_sel_data;
            end else begin
               r_wr_en <= 1'b0;
               if (r_drop != '1) begin
                  r_drop <= r_drop + 1'b1;
               end
               if (w_sel_idx != IDX_ZERO) begin
                  r_err     <= 1'b1;
                  r_err_src <= w_gnt;
               end
            end
         end else if (wr_ready) begin
            r_wr_en <= 1'b0;
         end
      end
   end

   assign wr_en       = r_wr_en;
   assign wr_idx      = r_wr_idx;
   assign wr_data     = r_wr_data;
   assign err_bad_idx = r_err;
   assign err_src     = r_err_src;
   assign drop_count  = r_drop;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single architectural register-file write port among NUM_REQ writeback sources (ALU, load unit, branch unit, system unit).
- Arbitration is round-robin with valid/ready handshakes into a one-entry registered output stage.
- Register index encoding: R0..R31 = 0..31, SP = 32, BP = 33, FLAGS = 34, PC = 35, ZERO = 36.
- Writes to ZERO, and to any index above 36, are consumed and discarded so they never reach the register file.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).
- DATA_W, 64, register data width.
- IDX_W, 8, register index width; matches the register enum width.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_idx  in  NUM_REQ*IDX_W  per-requester destination index; requester i occupies bits [i*IDX_W +: IDX_W].
- req_data  in  NUM_REQ*DATA_W  per-requester write data.
- req_ready  out  NUM_REQ  one-hot grant; the request is consumed when valid&ready.
- wr_en  out  1  register-file write strobe.
- wr_idx  out  IDX_W  register-file write index.
- wr_data  out  DATA_W  register-file write data.
- wr_ready  in  1  the register file accepts the write when wr_en&wr_ready.
- err_bad_idx  out  1  one-cycle pulse: an index >36 was consumed.
- err_src  out  3  requester number of the last bad-index consume.
- drop_count  out  CNT_W  saturating count of discarded requests (ZERO plus bad index).

Behaviour:
- Async reset (rst_n=0) clears wr_en, wr_idx, wr_data, err_bad_idx, err_src, drop_count and the priority pointer, all to 0. Reset takes effect immediately, even mid-transfer; a held write is lost.
- Output stage is free when wr_en=0 or wr_en&wr_ready.
- Grant, combinational: when the stage is free, select the first valid requester starting at pointer ptr and searching upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ...).
  - req_ready is one-hot on the selected requester.
  - req_ready is all zero when the stage is not free or no request is valid.
- req_ready never depends on req_idx. ZERO and bad-index requests still consume a grant slot.
- On a grant to requester g:
  - ptr <= (g+1) mod NUM_REQ.
  - If idx <= 35: next cycle wr_en=1, wr_idx=idx, wr_data=data. Latency is exactly 1 cycle.
  - If idx == 36 (ZERO): wr_en=0 next cycle (or falls to 0 if the previous write completed); drop_count += 1.
  - If idx > 36: same as ZERO, plus err_bad_idx=1 for one cycle and err_src=g.
- Backpressure: while wr_en=1 and wr_ready=0, wr_idx and wr_data hold stable and no grant is issued.
- Back-to-back: when wr_ready=1 in the same cycle as a new grant, the stage reloads with no bubble, giving a sustained one write per cycle.
- No grant cycle: ptr is unchanged; wr_en drops to 0 after a completing write.
- drop_count saturates at 2^CNT_W-1 and never wraps.
- err_bad_idx deasserts the cycle after its pulse unless another bad index is consumed.
- A requester must hold req_valid, req_idx and req_data until it sees ready; the arbiter does not check this.

Test Plan:
- Single request: requester 1 writes idx=5, data=0xDEAD_BEEF, wr_ready=1 -> req_ready=4'b0010 in cycle T; wr_en=1, wr_idx=5, wr_data=0xDEADBEEF in T+1; wr_en=0 in T+2.
- Round-robin: all 4 requesters continuously valid, wr_ready=1, after reset -> grant order 0,1,2,3,0,1; one write per cycle with no bubbles.
- Backpressure: wr_ready=0 for 3 cycles with a write pending and requesters 0 and 2 valid -> wr_idx and wr_data stable, req_ready=0 throughout; on release, requester 2 is granted if ptr=1.
- Discard: idx=36 from requester 3 -> granted, wr_en stays 0, drop_count 0->1, no error. idx=40 from requester 2 -> drop_count=2, err_bad_idx pulses one cycle, err_src=2.
- Special registers: idx=35 (PC) and idx=34 (FLAGS) -> written normally with wr_idx=35 and 34 respectively.
- Reset mid-operation: rst_n low while wr_en=1 and wr_ready=0 -> wr_en, drop_count and ptr are 0 immediately. After release, requester 0 wins first when all requesters are valid.
